mux_16x1_rr: RTL

Sixteen-channel round-robin collector: the sending end of the 1-to-16 demux path. It gathers requests from 16 sources, grants one per accept cycle in round-robin order, and emits a single registered stream tagged with the 4-bit channel select code. Downstream, a 1x16 demux uses that code to route the data back out. It sits between the per-channel producers and the shared serial link.

---
 rtl/mux_16x1_rr_pkg.sv | 9 +
 rtl/mux_16x1_rr_pick.sv | 25 ++
 rtl/mux_16x1_rr.sv | 46 ++++
 3 files changed

// File: rtl/mux_16x1_rr_pkg.sv
// mux_16x1_rr_pkg: shared constants, output-stage states and select helper
package mux_pkg;
    localparam int N_CH  = 16;
    localparam int SEL_W = 4;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] sel);
        return SEL_W'((32'(sel) + 1) % N_CH);
    endfunction
endpackage

// File: rtl/mux_16x1_rr_pick.sv
// rr_pick16: finds the first requesting channel at or above ptr, wrapping 15->0
module rr_pick16
    import mux_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_CH-1:0]  onehot
);
    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [SEL_W-1:0]  off;
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N_CH-1:0];
    // lowest set bit of the rotated request vector is the offset from ptr
    always_comb begin
        off = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (rot[i]) off = SEL_W'(i);
    end
    assign any    = |req;
    assign idx    = off + ptr;
    assign onehot = any ? N_CH'(1) << idx : '0;
endmodule

// File: rtl/mux_16x1_rr.sv
// mux_16x1_rr: 16-channel round-robin collector into one registered tagged stream
module mux_16x1_rr
    import mux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH*DW-1:0] din,
    output logic [N_CH-1:0]   gnt,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [SEL_W-1:0]  out_sel,
    input  logic              out_ready
);
    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, idx;
    logic [N_CH-1:0]  onehot;
    logic             any, load, take;
    rr_pick16 u_pick (.req(req), .ptr(ptr), .any(any), .idx(idx), .onehot(onehot));
    assign out_valid = state == FULL;
    assign load      = ~out_valid | out_ready;
    assign take      = load & any;
    assign gnt       = (take & ~rst) ? onehot : '0;
    // output stage occupancy register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    // refill on a grant, drain when the consumer takes the word and nobody asks
    always_comb begin
        state_nxt = state;
        if (load) state_nxt = any ? FULL : EMPTY;
    end
    // capture the granted word and move the search start past the winner
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else if (take) begin
            out_data <= din[idx*DW +: DW];
            out_sel  <= idx;
            ptr      <= wrap_inc(idx);
        end
endmodule
